// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
package instr_mem_pkg;

   localparam int unsigned READ_LATENCY_MAX    = 4;
   localparam int unsigned MAX_OUTSTANDING_MAX = 4;

   // Fibonacci LFSR, taps 16,14,13,11 expressed as a mask over the shift-out end.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch request/grant/valid bus; the fetch stage is the master.
interface instr_mem_responder_if;

   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_valid;
   logic [31:0] instr_rdata;
   logic        instr_err;

   modport master (
      output instr_req,
      output instr_addr,
      input  instr_gnt,
      input  instr_valid,
      input  instr_rdata,
      input  instr_err
   );

   modport slave (
      input  instr_req,
      input  instr_addr,
      output instr_gnt,
      output instr_valid,
      output instr_rdata,
      output instr_err
   );

endinterface

// File: rtl/instr_mem_resp_pipe.sv
// Fixed-depth response delay line with a valid bit per stage and synchronous clear.
module instr_mem_resp_pipe
   import instr_mem_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic  clk_i,
   input  logic  clr_i,
   input  logic  in_valid_i,
   input  resp_t in_resp_i,
   output logic  out_valid_o,
   output resp_t out_resp_o
);

   logic [Depth-1:0] valid_q;
   resp_t            resp_q [Depth];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            resp_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid_i;
         resp_q[0]  <= in_valid_i ? in_resp_i : '0;
         for (int i = 1; i < Depth; i++) begin
            valid_q[i] <= valid_q[i-1];
            resp_q[i]  <= resp_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[Depth-1];
   assign out_resp_o  = resp_q[Depth-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: program memory behind a req/gnt/valid port with fixed
// read latency, a bounded number of outstanding grants and optional LFSR grant throttling.
module instr_mem_responder
   import instr_mem_pkg::*;
#(
   parameter int unsigned  DEPTH_WORDS     = 1024,
   parameter logic [31:0]  BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned  READ_LATENCY    = 1,
   parameter int unsigned  MAX_OUTSTANDING = 2,
   parameter bit           RANDOM_STALL    = 1'b0,
   localparam int unsigned AddrW           = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   instr_mem_responder_if.slave bus,
   input  logic                 gnt_stall,
   input  logic                 mem_we,
   input  logic [AddrW-1:0]     mem_waddr,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_wbe
);

   localparam logic [32:0] MemSpan = 33'(DEPTH_WORDS) << 2;

   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two");
   end
   if ((BASE_ADDR & (MemSpan[31:0] - 32'd1)) != 32'd0) begin : g_bad_base
      $error("BASE_ADDR must be aligned to the memory size");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_lat
      $error("READ_LATENCY out of range");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_MAX) begin : g_bad_out
      $error("MAX_OUTSTANDING out of range");
   end

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [2:0]       outst_q, outst_d;
   logic [15:0]      lfsr_q;
   logic             lfsr_stall;
   logic             gnt;
   logic [31:0]      offset;
   logic             addr_ok;
   logic [AddrW-1:0] rd_idx;
   resp_t            rd_resp;
   resp_t            out_resp;
   logic             out_valid;

   assign lfsr_stall = RANDOM_STALL && (lfsr_q[1:0] == 2'b00);
   assign gnt        = reset_n & bus.instr_req & ~gnt_stall & ~lfsr_stall
                       & (outst_q < 3'(MAX_OUTSTANDING));

   assign offset  = bus.instr_addr - BASE_ADDR;
   assign addr_ok = (bus.instr_addr >= BASE_ADDR) && ({1'b0, offset} < MemSpan)
                    && (bus.instr_addr[1:0] == 2'b00);
   assign rd_idx  = offset[AddrW+1:2];

   // Combinational read of the current array contents gives read-before-write on a
   // same-cycle load-port write.
   always_comb begin
      rd_resp = '0;
      if (addr_ok) rd_resp.rdata = mem_q[rd_idx];
      else         rd_resp.err   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wbe[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign outst_d = outst_q + 3'(gnt) - 3'(out_valid);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         outst_q <= 3'd0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         outst_q <= outst_d;
         lfsr_q  <= lfsr_next(lfsr_q);
      end
   end

   instr_mem_resp_pipe #(
      .Depth (READ_LATENCY)
   ) u_pipe (
      .clk_i       (clk),
      .clr_i       (~reset_n),
      .in_valid_i  (gnt),
      .in_resp_i   (rd_resp),
      .out_valid_o (out_valid),
      .out_resp_o  (out_resp)
   );

   assign bus.instr_gnt   = gnt;
   assign bus.instr_valid = out_valid;
   assign bus.instr_rdata = out_resp.rdata;
   assign bus.instr_err   = out_resp.err;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (outst_q <= 3'(MAX_OUTSTANDING))
         else $error("outstanding counter above limit");
         assert (!(out_valid && !gnt && outst_q == 3'd0))
         else $error("outstanding counter underflow");
      end
   end

endmodule
